// File: rtl/axi4_slv_pkg.sv
// -----------------------------------------------------------------------------
// axi4_slv_pkg
// Shared constants and state types for the AXI4 slave memory.
//   BURST_*   : AxBURST encodings
//   RESP_*    : xRESP encodings
//   w_state_t : write-channel FSM states
//   r_state_t : read-channel FSM states
// -----------------------------------------------------------------------------
package axi4_slv_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

// File: rtl/axi4_slave_mem_if.sv
// -----------------------------------------------------------------------------
// axi4_slave_mem_if
// AXI4-Full bus bundle (AW, W, B, AR, R channels, no USER signals).
//   master modport : drives addresses, write data, bready/rready
//   slave  modport : drives readies, B response, R data
// Lock/cache/prot/qos are carried so a master can drive them; the slave
// memory ignores them.
// -----------------------------------------------------------------------------
interface axi4_slave_mem_if #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // write address
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic                    awvalid;
    logic                    awready;
    // write data
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    // write response
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    // read address
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic                    arvalid;
    logic                    arready;
    // read data
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi4_slv_addr_gen.sv
// -----------------------------------------------------------------------------
// axi4_slv_addr_gen
// Combinational beat address helper, one instance per channel.
//   addr      : byte address of the current beat
//   size      : AxSIZE of the burst
//   burst     : AxBURST of the burst
//   next_addr : byte address of the following beat (FIXED holds, others step)
//   word_idx  : RAM word index of addr
//   in_range  : addr maps onto a RAM word
//   cfg_err   : burst type or beat size not supported (answered with SLVERR)
// -----------------------------------------------------------------------------
module axi4_slv_addr_gen
    import axi4_slv_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    localparam int                   IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic [IDX_W-1:0]      word_idx,
    output logic                  in_range,
    output logic                  cfg_err
);
    localparam int LSB = $clog2(DATA_WIDTH / 8);

    logic                  below_base;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] word_full;

    // WRAP and reserved encodings still step like INCR; only the response differs.
    assign next_addr = (burst == BURST_FIXED) ? addr : addr + (ADDR_WIDTH'(1) << size);

    // The borrow out of the subtraction flags an address below the base.
    assign {below_base, offset} = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign word_full = offset >> LSB;
    assign word_idx  = word_full[IDX_W-1:0];
    assign in_range  = !below_base && (word_full < ADDR_WIDTH'(MEM_DEPTH));

    assign cfg_err = ((burst != BURST_FIXED) && (burst != BURST_INCR)) || (size != 3'(LSB));

endmodule

// File: rtl/axi4_slave_mem.sv
// -----------------------------------------------------------------------------
// axi4_slave_mem
// AXI4-Full slave backed by a word-addressed RAM. One write burst and one
// read burst may be in flight at once; the two channels run independently.
//   ACLK   : clock, rising edge
//   ARESET : synchronous active-high reset
//   s_axi  : AXI4 slave bus (axi4_slave_mem_if.slave)
// Build option: define AXI_SLV_BACKPRESSURE_EN to gate WREADY/ARREADY with a
// free-running 16-bit LFSR for random stalls.
// -----------------------------------------------------------------------------
module axi4_slave_mem
    import axi4_slv_pkg::*;
#(
    parameter int                            C_S_AXI_ID_WIDTH   = 1,
    parameter int                            C_S_AXI_ADDR_WIDTH = 32,
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter int                            C_MEM_DEPTH        = 1024,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0
) (
    input logic               ACLK,
    input logic               ARESET,
    axi4_slave_mem_if.slave   s_axi
);
    localparam int IDW    = C_S_AXI_ID_WIDTH;
    localparam int AW     = C_S_AXI_ADDR_WIDTH;
    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = DW / 8;
    localparam int IDX_W  = $clog2(C_MEM_DEPTH);

    // Readies are held off until the first edge after reset has released.
    logic live;
    always_ff @(posedge ACLK) begin
        // NOTE: state updates use non-blocking assignments so every flop
        // samples pre-edge values regardless of block order.
        if (ARESET) live <= 1'b0;
        else        live <= 1'b1;
    end

    logic ready_gate;
`ifdef AXI_SLV_BACKPRESSURE_EN
    logic [15:0] lfsr;
    always_ff @(posedge ACLK) begin
        if (ARESET) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign ready_gate = lfsr[0];
`else
    assign ready_gate = 1'b1;
`endif

    // Sideband attributes are accepted but carry no meaning for a plain RAM.
    logic unused_sideband;
    assign unused_sideband = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                               s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos};

    logic [DW-1:0] mem [C_MEM_DEPTH];

    // ------------------------------------------------------------------ write
    w_state_t         w_state, w_state_nxt;
    logic [IDW-1:0]   aw_id;
    logic [AW-1:0]    w_addr, w_next_addr;
    logic [7:0]       aw_len, w_cnt;
    logic [2:0]       aw_size;
    logic [1:0]       aw_burst;
    logic             w_err;
    logic [IDX_W-1:0] w_idx;
    logic             w_in_range, w_cfg_err;
    logic             aw_ready, w_ready, b_valid;
    logic             aw_hs, w_hs, w_last_beat, w_beat_err;

    axi4_slv_addr_gen #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(C_MEM_DEPTH), .BASE_ADDR(C_BASE_ADDR)
    ) u_w_addr_gen (
        .addr(w_addr), .size(aw_size), .burst(aw_burst), .next_addr(w_next_addr),
        .word_idx(w_idx), .in_range(w_in_range), .cfg_err(w_cfg_err)
    );

    assign aw_hs       = aw_ready && s_axi.awvalid;
    assign w_hs        = w_ready && s_axi.wvalid;
    assign w_last_beat = (w_cnt == aw_len);
    // WLAST must coincide exactly with the final counted beat.
    assign w_beat_err  = w_cfg_err || !w_in_range || (s_axi.wlast != w_last_beat);

    always_ff @(posedge ACLK) begin
        if (ARESET) w_state <= W_IDLE;
        else        w_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        w_state_nxt = w_state;
        aw_ready    = 1'b0;
        w_ready     = 1'b0;
        b_valid     = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                aw_ready = live;
                if (aw_ready && s_axi.awvalid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                w_ready = ready_gate;
                if (w_ready && s_axi.wvalid && w_last_beat) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (s_axi.bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_id    <= '0;
            w_addr   <= '0;
            aw_len   <= '0;
            aw_size  <= '0;
            aw_burst <= '0;
            w_cnt    <= '0;
            w_err    <= 1'b0;
        end else if (aw_hs) begin
            aw_id    <= s_axi.awid;
            w_addr   <= s_axi.awaddr;
            aw_len   <= s_axi.awlen;
            aw_size  <= s_axi.awsize;
            aw_burst <= s_axi.awburst;
            w_cnt    <= '0;
            w_err    <= 1'b0;
        end else if (w_hs) begin
            w_addr <= w_next_addr;
            w_cnt  <= w_cnt + 8'd1;
            if (w_beat_err) w_err <= 1'b1;
        end
    end

    // NOTE: the RAM has no reset so it maps onto block memory; only its
    // control path is reset.
    always_ff @(posedge ACLK) begin
        if (!ARESET && w_hs && w_in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi.wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
            end
        end
    end

    assign s_axi.awready = aw_ready;
    assign s_axi.wready  = w_ready;
    assign s_axi.bvalid  = b_valid;
    assign s_axi.bid     = aw_id;
    assign s_axi.bresp   = (b_valid && w_err) ? RESP_SLVERR : RESP_OKAY;

    // ------------------------------------------------------------------- read
    r_state_t         r_state, r_state_nxt;
    logic [IDW-1:0]   ar_id;
    logic [AW-1:0]    r_addr, r_lk_addr, r_next_addr;   // r_addr: next beat to fetch
    logic [7:0]       ar_len, r_cnt;
    logic [2:0]       ar_size, r_lk_size;
    logic [1:0]       ar_burst, r_lk_burst;
    logic [IDX_W-1:0] r_idx;
    logic             r_in_range, r_cfg_err;
    logic             ar_ready, r_valid, r_last;
    logic             ar_hs, r_hs;
    logic [DW-1:0]    r_data;
    logic [1:0]       r_resp;

    // In IDLE the fetch address comes straight off AR so the first beat is
    // ready the cycle after the handshake.
    assign r_lk_addr  = (r_state == R_IDLE) ? s_axi.araddr  : r_addr;
    assign r_lk_size  = (r_state == R_IDLE) ? s_axi.arsize  : ar_size;
    assign r_lk_burst = (r_state == R_IDLE) ? s_axi.arburst : ar_burst;

    axi4_slv_addr_gen #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(C_MEM_DEPTH), .BASE_ADDR(C_BASE_ADDR)
    ) u_r_addr_gen (
        .addr(r_lk_addr), .size(r_lk_size), .burst(r_lk_burst), .next_addr(r_next_addr),
        .word_idx(r_idx), .in_range(r_in_range), .cfg_err(r_cfg_err)
    );

    assign ar_hs  = ar_ready && s_axi.arvalid;
    assign r_hs   = r_valid && s_axi.rready;
    assign r_last = (r_state == R_DATA) && (r_cnt == ar_len);

    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= R_IDLE;
        else        r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        ar_ready    = 1'b0;
        r_valid     = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                ar_ready = live && ready_gate;
                if (ar_ready && s_axi.arvalid) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                r_valid = 1'b1;
                if (s_axi.rready && r_last) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ar_id    <= '0;
            r_addr   <= '0;
            ar_len   <= '0;
            ar_size  <= '0;
            ar_burst <= '0;
            r_cnt    <= '0;
            r_data   <= '0;
            r_resp   <= RESP_OKAY;
        end else if (ar_hs || (r_hs && !r_last)) begin
            if (ar_hs) begin
                ar_id    <= s_axi.arid;
                ar_len   <= s_axi.arlen;
                ar_size  <= s_axi.arsize;
                ar_burst <= s_axi.arburst;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
            r_addr <= r_next_addr;
            // Same-cycle write to this word lands after this read: old data.
            r_data <= r_in_range ? mem[r_idx] : '0;
            r_resp <= (r_in_range && !r_cfg_err) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign s_axi.arready = ar_ready;
    assign s_axi.rvalid  = r_valid;
    assign s_axi.rlast   = r_last;
    assign s_axi.rid     = ar_id;
    assign s_axi.rdata   = r_data;
    assign s_axi.rresp   = r_resp;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_axi4_slave_mem
// Directed bench for axi4_slave_mem. A byte-accurate memory model predicts
// read data and responses; expectations are queued when a request is issued
// and compared when the slave answers.
// -----------------------------------------------------------------------------
module tb_axi4_slave_mem;
    import axi4_slv_pkg::*;

    localparam int IDW    = 1;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int DEPTH  = 1024;
    localparam int BUDGET = 50;

    logic ACLK = 1'b0;
    logic ARESET;
    always #5 ACLK = ~ACLK;

    axi4_slave_mem_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4_slave_mem #(
        .C_S_AXI_ID_WIDTH(IDW), .C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_DATA_WIDTH(DW),
        .C_MEM_DEPTH(DEPTH), .C_BASE_ADDR(32'h0)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .s_axi(bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  id;
    } r_exp_t;

    typedef struct packed {
        logic [0:0] id;
        logic [1:0] resp;
    } b_exp_t;

    r_exp_t      r_q[$];
    b_exp_t      b_q[$];
    logic [31:0] model [DEPTH];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] a0, input int i, input logic [1:0] burst);
        return (burst == BURST_FIXED) ? a0 : a0 + 32'(i * 4);
    endfunction

    // ---------------------------------------------------------------- write
    task automatic aw_send(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        int n;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = 3'd2;
        bus.awburst = burst; bus.awvalid = 1'b1;
        n = 0;
        while (bus.awready !== 1'b1 && n < BUDGET) begin @(negedge ACLK); n++; end
        check("aw_handshake_in_budget", 64'(n < BUDGET), 64'd1);
        @(negedge ACLK);
        bus.awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n;
        bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
        n = 0;
        while (bus.wready !== 1'b1 && n < BUDGET) begin @(negedge ACLK); n++; end
        check("w_handshake_in_budget", 64'(n < BUDGET), 64'd1);
        @(negedge ACLK);
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    task automatic write_burst(input logic [0:0] id, input logic [31:0] addr, input int len,
                               input logic [1:0] burst, input logic [31:0] data0,
                               input logic [31:0] step, input logic [3:0] strb, input int last_at);
        logic        err;
        logic [31:0] a, d;
        b_exp_t      e;
        err = (burst != BURST_FIXED) && (burst != BURST_INCR);
        aw_send(id, addr, 8'(len), burst);
`ifndef AXI_SLV_BACKPRESSURE_EN
        check("wready_cycle_after_aw", 64'(bus.wready), 64'd1);
`endif
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, i, burst);
            d = data0 + 32'(i) * step;
            if (a >= 32'(DEPTH * 4)) begin
                err = 1'b1;
            end else begin
                for (int b = 0; b < 4; b++) if (strb[b]) model[a >> 2][b*8 +: 8] = d[b*8 +: 8];
            end
            if ((i == last_at) != (i == len)) err = 1'b1;
            w_beat(d, strb, i == last_at);
        end
        e.id   = id;
        e.resp = err ? RESP_SLVERR : RESP_OKAY;
        b_q.push_back(e);
    endtask

    task automatic b_recv(input string tag);
        int     n;
        b_exp_t e;
        bus.bready = 1'b1;
        n = 0;
        while (bus.bvalid !== 1'b1 && n < BUDGET) begin @(negedge ACLK); n++; end
        check({tag, "_bvalid_cycle_after_last_w"}, 64'(n), 64'd0);
        check({tag, "_b_expected"}, 64'(b_q.size() > 0), 64'd1);
        if (b_q.size() > 0) begin
            e = b_q.pop_front();
            check({tag, "_bresp"}, 64'(bus.bresp), 64'(e.resp));
            check({tag, "_bid"}, 64'(bus.bid), 64'(e.id));
        end
        @(negedge ACLK);
        bus.bready = 1'b0;
    endtask

    // ----------------------------------------------------------------- read
    task automatic ar_send(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        int n;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = 3'd2;
        bus.arburst = burst; bus.arvalid = 1'b1;
        n = 0;
        while (bus.arready !== 1'b1 && n < BUDGET) begin @(negedge ACLK); n++; end
        check("ar_handshake_in_budget", 64'(n < BUDGET), 64'd1);
        @(negedge ACLK);
        bus.arvalid = 1'b0;
    endtask

    task automatic read_req(input logic [0:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst);
        logic [31:0] a;
        logic        bad;
        r_exp_t      e;
        bad = (burst != BURST_FIXED) && (burst != BURST_INCR);
        for (int i = 0; i <= len; i++) begin
            a      = beat_addr(addr, i, burst);
            e.id   = id;
            e.last = (i == len);
            if (a >= 32'(DEPTH * 4)) begin
                e.data = 32'h0;
                e.resp = RESP_SLVERR;
            end else begin
                e.data = model[a >> 2];
                e.resp = bad ? RESP_SLVERR : RESP_OKAY;
            end
            r_q.push_back(e);
        end
        ar_send(id, addr, 8'(len), burst);
        check("rvalid_cycle_after_ar", 64'(bus.rvalid), 64'd1);
    endtask

    task automatic r_recv(input string tag, input int beats);
        int     n;
        r_exp_t e;
        bus.rready = 1'b1;
        for (int i = 0; i < beats; i++) begin
            n = 0;
            while (bus.rvalid !== 1'b1 && n < BUDGET) begin @(negedge ACLK); n++; end
            check({tag, "_rvalid_back_to_back"}, 64'(n), 64'd0);
            check({tag, "_r_expected"}, 64'(r_q.size() > 0), 64'd1);
            if (r_q.size() > 0) begin
                e = r_q.pop_front();
                check({tag, "_rdata"}, 64'(bus.rdata), 64'(e.data));
                check({tag, "_rresp"}, 64'(bus.rresp), 64'(e.resp));
                check({tag, "_rlast"}, 64'(bus.rlast), 64'(e.last));
                check({tag, "_rid"}, 64'(bus.rid), 64'(e.id));
            end
            @(negedge ACLK);
        end
        bus.rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        r_exp_t peek;
        ARESET = 1'b1;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = BURST_INCR;
        bus.awlock = 1'b0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = BURST_INCR;
        bus.arlock = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        // Reset held four cycles: every output at its reset value.
        repeat (4) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_awready", 64'(bus.awready), 64'd0);
        check("rst_wready",  64'(bus.wready),  64'd0);
        check("rst_bvalid",  64'(bus.bvalid),  64'd0);
        check("rst_arready", 64'(bus.arready), 64'd0);
        check("rst_rvalid",  64'(bus.rvalid),  64'd0);
        check("rst_rlast",   64'(bus.rlast),   64'd0);
        check("rst_bid_bresp", 64'({bus.bid, bus.bresp}), 64'd0);
        check("rst_rid_rresp", 64'({bus.rid, bus.rresp}), 64'd0);
        check("rst_rdata",   64'(bus.rdata),   64'd0);
        ARESET = 1'b0;
        check("awready_before_first_edge", 64'(bus.awready), 64'd0);
        @(negedge ACLK);
        check("awready_after_release", 64'(bus.awready), 64'd1);
`ifndef AXI_SLV_BACKPRESSURE_EN
        check("arready_after_release", 64'(bus.arready), 64'd1);
`endif

        // INCR write of four words, then read them back.
        write_burst(1'b1, 32'h0, 3, BURST_INCR, 32'h11, 32'h11, 4'hF, 3);
        b_recv("incr_wr");
        check("awready_back_after_b", 64'(bus.awready), 64'd1);
        read_req(1'b1, 32'h0, 3, BURST_INCR);
        r_recv("incr_rd", 4);

        // Byte strobes: only bytes 0 and 2 land.
        write_burst(1'b0, 32'h0, 0, BURST_INCR, 32'hAABBCCDD, 32'h0, 4'b0101, 0);
        b_recv("strb_wr");
        read_req(1'b0, 32'h0, 0, BURST_INCR);
        r_recv("strb_rd", 1);

        // Early WLAST gives SLVERR; the next burst is clean again.
        write_burst(1'b1, 32'h40, 3, BURST_INCR, 32'h10000001, 32'h01010101, 4'hF, 1);
        b_recv("early_wlast");
        write_burst(1'b0, 32'((DEPTH - 1) * 4), 0, BURST_INCR, 32'hCAFEF00D, 32'h0, 4'hF, 0);
        b_recv("top_word_wr");

        // Write that runs off the top of the RAM.
        write_burst(1'b1, 32'((DEPTH - 1) * 4), 1, BURST_INCR, 32'h55550000, 32'h1, 4'hF, 1);
        b_recv("oor_wr");
        read_req(1'b0, 32'((DEPTH - 1) * 4), 1, BURST_INCR);
        r_recv("oor_rd", 2);

        // FIXED bursts hold the address; WRAP is answered with SLVERR.
        write_burst(1'b0, 32'h80, 1, BURST_FIXED, 32'h11111111, 32'h11111111, 4'hF, 1);
        b_recv("fixed_wr");
        read_req(1'b1, 32'h80, 2, BURST_FIXED);
        r_recv("fixed_rd", 3);
        read_req(1'b0, 32'h0, 1, BURST_WRAP);
        r_recv("wrap_rd", 2);

        // Reset in the middle of a stalled eight-beat read.
        read_req(1'b1, 32'h0, 7, BURST_INCR);
        r_recv("pre_rst_rd", 2);
        @(negedge ACLK);
        peek = r_q[0];
        check("stall_rvalid_held", 64'(bus.rvalid), 64'd1);
        check("stall_rdata_held", 64'(bus.rdata), 64'(peek.data));
        ARESET = 1'b1;
        @(negedge ACLK);
        check("midrst_rvalid", 64'(bus.rvalid), 64'd0);
        check("midrst_rdata", 64'(bus.rdata), 64'd0);
        check("midrst_arready", 64'(bus.arready), 64'd0);
        r_q.delete();
        ARESET = 1'b0;
        @(negedge ACLK);
        read_req(1'b0, 32'h40, 3, BURST_INCR);
        r_recv("post_rst_rd", 4);
        write_burst(1'b1, 32'h100, 0, BURST_INCR, 32'h0BADF00D, 32'h0, 4'hF, 0);
        b_recv("post_rst_wr");
        read_req(1'b1, 32'h100, 0, BURST_INCR);
        r_recv("post_rst_rd2", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_slave_mem.md
# axi4_slave_mem

Synthesizable AXI4-Full slave memory that terminates the M00 AXI4 master port of the burst-transaction master under test. It sits directly downstream of the master on all five channels and accepts its INCR write bursts into a word-addressed RAM. It returns the same data on read bursts, with OKAY/SLVERR responses, so that the master's TXN_DONE/ERROR behaviour can be exercised end to end. One write burst and one read burst may be in flight at a time; the two run concurrently and independently.

## Interface
- C_S_AXI_ID_WIDTH, 1, ID width on AW/B/AR/R
- C_S_AXI_ADDR_WIDTH, 32, byte address width
- C_S_AXI_DATA_WIDTH, 32, data width (32 or 64)
- C_MEM_DEPTH, 1024, RAM depth in data words
- C_BASE_ADDR, 32'h0, byte address of word 0

Ports (one clock; reset is synchronous and active-high):
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  synchronous active-high reset
- AWID/AWADDR/AWLEN(8)/AWSIZE(3)/AWBURST(2)/AWVALID  in; AWREADY  out  — write address channel
- WDATA/WSTRB(DATA/8)/WLAST/WVALID  in; WREADY  out  — write data channel
- BID/BRESP(2)/BVALID  out; BREADY  in  — write response channel
- ARID/ARADDR/ARLEN(8)/ARSIZE(3)/ARBURST(2)/ARVALID  in; ARREADY  out  — read address channel
- RID/RDATA/RRESP(2)/RLAST/RVALID  out; RREADY  in  — read data channel
- AWLOCK/AWCACHE/AWPROT/AWQOS/AR equivalents: accepted and ignored; no USER ports.

## Operation
- Write FSM W_IDLE→W_DATA→W_RESP→W_IDLE. In W_IDLE: AWREADY=1. On AW handshake, capture ID, address, LEN, SIZE and BURST; clear the error flag.
- In W_DATA: WREADY=1. On each W handshake:
  - write the bytes enabled by WSTRB to the current word;
  - advance the address;
  - increment the beat count.
- Leave W_DATA on the beat where count==AWLEN. WLAST asserted on any other beat, or deasserted on that beat, sets the error flag.
- In W_RESP: BVALID=1, BID=captured ID, BRESP=SLVERR(2'b10) if the error flag is set, else OKAY. Hold until BREADY, then return to W_IDLE.
- Read FSM R_IDLE→R_DATA→R_IDLE. In R_IDLE: ARREADY=1. The AR handshake captures the burst and loads RDATA with the first word.
- In R_DATA: RVALID=1, RID=captured ID, RLAST=(count==ARLEN). Each R handshake loads the next word. The handshake on the RLAST beat returns to R_IDLE.
- Address generation:
  - FIXED: address is held.
  - INCR: address += 2^SIZE.
  - WRAP and reserved encodings: INCR addressing with SLVERR.
  - SIZE ≠ log2(DATA/8): SLVERR.
- Word index = (addr−C_BASE_ADDR)>>log2(DATA/8). An index ≥ C_MEM_DEPTH, or an addr below the base, makes that beat out of range:
  - writes to it are dropped and the B response is SLVERR;
  - reads from it return 0 with RRESP=SLVERR for that beat only.
- RAM contents are not reset.

## Timing
- Reset values: AWREADY/WREADY/BVALID/ARREADY/RVALID/RLAST = 0; BID/BRESP/RID/RDATA/RRESP = 0.
- AWREADY and ARREADY rise one cycle after ARESET deasserts.
- AW handshake at cycle N → WREADY at N+1. Last W beat at M → BVALID at M+1.
- AR handshake at N → RVALID with the first beat at N+1. Back-to-back beats run at 1/cycle when RREADY is held high.
- Once asserted, RVALID/BVALID and their payloads stay stable until handshake.
- After a handshake, AWREADY/ARREADY stay low until the FSM returns to IDLE, which is the cycle after B/last-R handshake.
- Simultaneous read and write to the same word in one cycle: the read returns the old data.
- ARESET asserted mid-burst: both FSMs go to IDLE next edge, all valids/readies drop, and the partial burst is abandoned with no response.

## Configuration
- AXI_SLV_BACKPRESSURE_EN defined: a 16-bit LFSR (seed 16'hACE1, stepped every cycle) gates the ready signals.
  - WREADY and ARREADY are asserted only when lfsr[0]=1, giving random stalls.
  - The protocol rules above still hold.
- Undefined: WREADY/ARREADY are always 1 in their states and no LFSR is instantiated.

## Structure
- Package axi4_slv_pkg holds:
  - BURST_FIXED/INCR/WRAP constants;
  - RESP_OKAY/SLVERR constants;
  - w_state_t and r_state_t enums.
- Sub-module axi4_slv_addr_gen (combinational next-address plus range check) is instantiated once per channel.

## Test plan
- Reset: hold ARESET 4 cycles → all outputs 0; AWREADY=ARREADY=1 on the first cycle after release.
- Write INCR AWADDR=0x0, LEN=3, data 0x11..0x44, then read the same address back → BRESP=OKAY, RDATA=0x11,0x22,0x33,0x44, RLAST only on the 4th beat.
- Write 0xAABBCCDD with WSTRB=4'b0101 over 0x0, then read → 0x00BB00DD.
- WLAST asserted on beat 2 of an AWLEN=3 write → BRESP=SLVERR.
- Read ARADDR=(C_MEM_DEPTH−1)*4, LEN=1 → beat 0 OKAY with stored data; beat 1 RDATA=0, RRESP=SLVERR.
- Assert ARESET during beat 2 of a LEN=7 read with RREADY stalled → RVALID=0 next cycle; a new burst completes normally afterward.
